// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial packed-BCD adder controller: one decimal digit per clock, LSD first,
// with the decimal carry rippled through a register between digit steps.
module bcd_serial_add_ctrl #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  cin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  err
);

    localparam int unsigned W  = 4 * DIGITS;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic           c_q;
    logic [IW-1:0]  idx;
    logic           accept_c;
    logic           last_c;
    logic           carry_c;
    logic           bad_c;
    logic [4:0]     t_c;
    logic [3:0]     digit_c;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and digit step; operand registers shift so the current digit is always at [3:0]
    always_comb begin
        state_next = state;
        accept_c   = 1'b0;
        carry_c    = 1'b0;
        digit_c    = 4'd0;
        t_c        = 5'(a_q[3:0]) + 5'(b_q[3:0]) + 5'(c_q);
        bad_c      = (a_q[3:0] > 4'd9) || (b_q[3:0] > 4'd9);
        last_c     = (idx == IW'(DIGITS - 1));
        if (t_c > 5'd9) begin
            digit_c = 4'(t_c + 5'd6);
            carry_c = 1'b1;
        end else begin
            digit_c = t_c[3:0];
        end
        case (state)
            IDLE: begin
                if (start) begin
                    accept_c   = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_c) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath and registered outputs; done trails the DONE state by one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q  <= '0;
            b_q  <= '0;
            c_q  <= 1'b0;
            idx  <= '0;
            sum  <= '0;
            cout <= 1'b0;
            err  <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_next != IDLE);
            done <= (state == DONE);
            if (accept_c) begin
                a_q <= a;
                b_q <= b;
                c_q <= cin;
                idx <= '0;
                err <= 1'b0;
            end else if (state == RUN) begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (idx == IW'(i)) begin
                        sum[4*i +: 4] <= digit_c;
                    end
                end
                a_q <= a_q >> 4;
                b_q <= b_q >> 4;
                c_q <= carry_c;
                err <= err | bad_c;
                if (last_c) begin
                    cout <= carry_c;
                end else begin
                    idx <= idx + IW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Scoreboard bench for bcd_serial_add_ctrl: a 4-digit instance for the main scenarios
// and a 1-digit instance for the exhaustive single-digit sweep.
module tb_bcd_serial_add_ctrl;

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;
    logic        busy, done, cout, err;
    logic [15:0] sum;

    logic        start1 = 1'b0;
    logic [3:0]  a1 = '0;
    logic [3:0]  b1 = '0;
    logic        cin1 = 1'b0;
    logic        busy1, done1, cout1, err1;
    logic [3:0]  sum1;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    exp_t sb_q[$];
    int   sb1_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

    bcd_serial_add_ctrl #(.DIGITS(4)) u_dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .err(err)
    );

    bcd_serial_add_ctrl #(.DIGITS(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .err(err1)
    );

    // Decimal reference for valid BCD operands: convert to integers, add, convert back
    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic ci);
        int vx = 0;
        int vy = 0;
        int s;
        exp_t r;
        for (int i = 3; i >= 0; i--) begin
            vx = vx * 10 + int'(x[4*i +: 4]);
            vy = vy * 10 + int'(y[4*i +: 4]);
        end
        s = vx + vy + int'(ci);
        r.cout = (s >= 10000);
        s = s % 10000;
        for (int i = 0; i < 4; i++) begin
            r.sum[4*i +: 4] = 4'(s % 10);
            s = s / 10;
        end
        r.err = 1'b0;
        return r;
    endfunction

    // Pulse start, push expectation, wait (bounded) for done, pop expectation
    task automatic issue(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                         input exp_t want_in, output int lat, output exp_t got, output exp_t want);
        sb_q.push_back(want_in);
        a = ta; b = tb_v; cin = tc; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        a = $urandom; b = $urandom; cin = 1'(($urandom));
        lat = 0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
        end
        got  = '{sum: sum, cout: cout, err: err};
        want = sb_q.pop_front();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, done, sum, cout, err} !== 20'd0) begin
            n_fail++;
            $display("FAIL reset4: got busy=%b done=%b sum=%h cout=%b err=%b want all 0", busy, done, sum, cout, err);
        end
        n_checks++;
        if ({busy1, done1, sum1, cout1, err1} !== 8'd0) begin
            n_fail++;
            $display("FAIL reset1: got busy=%b done=%b sum=%h cout=%b err=%b want all 0", busy1, done1, sum1, cout1, err1);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int lat;
        exp_t got, want;
        issue(16'h1234, 16'h5678, 1'b0, '{16'h6912, 1'b0, 1'b0}, lat, got, want);
        n_checks++;
        if (lat !== 5) begin n_fail++; $display("FAIL basic_latency: got %0d want 5", lat); end
        n_checks++;
        if (got !== want) begin n_fail++; $display("FAIL basic_result: got %h want %h", got, want); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_at_done: got %b want 0", busy); end
    endtask

    task automatic test_carry();
        int lat;
        exp_t got, want;
        issue(16'h9999, 16'h0001, 1'b0, '{16'h0000, 1'b1, 1'b0}, lat, got, want);
        n_checks++;
        if (got !== want) begin n_fail++; $display("FAIL carry_ripple: got %h want %h", got, want); end
        issue(16'h0000, 16'h0000, 1'b1, '{16'h0001, 1'b0, 1'b0}, lat, got, want);
        n_checks++;
        if (got !== want) begin n_fail++; $display("FAIL carry_in: got %h want %h", got, want); end
        for (int n = 0; n < 6; n++) begin
            logic [15:0] ra, rb;
            logic rc;
            for (int i = 0; i < 4; i++) begin
                ra[4*i +: 4] = 4'($urandom_range(0, 9));
                rb[4*i +: 4] = 4'($urandom_range(0, 9));
            end
            rc = 1'($urandom_range(0, 1));
            issue(ra, rb, rc, model(ra, rb, rc), lat, got, want);
            n_checks++;
            if (got !== want) begin n_fail++; $display("FAIL random_%0d: a=%h b=%h cin=%b got %h want %h", n, ra, rb, rc, got, want); end
        end
    endtask

    task automatic test_single_digit();
        int bad = 0;
        for (int da = 0; da < 10; da++) begin
            for (int db = 0; db < 10; db++) begin
                for (int c = 0; c < 2; c++) begin
                    int lat = 0;
                    int want;
                    sb1_q.push_back(da + db + c);
                    a1 = 4'(da); b1 = 4'(db); cin1 = 1'(c); start1 = 1'b1;
                    @(posedge clk);
                    #1 start1 = 1'b0;
                    for (int k = 1; k <= 6; k++) begin
                        @(posedge clk);
                        #1;
                        if (done1) begin lat = k; break; end
                    end
                    want = sb1_q.pop_front();
                    n_checks++;
                    if (lat !== 2 || (10 * int'(cout1) + int'(sum1)) !== want || err1 !== 1'b0) begin
                        n_fail++;
                        bad++;
                        if (bad < 5)
                            $display("FAIL digit_sweep %0d+%0d+%0d: got lat=%0d cout=%b sum=%h err=%b want lat=2 value=%0d err=0",
                                     da, db, c, lat, cout1, sum1, err1, want);
                    end
                end
            end
        end
    endtask

    task automatic test_ignore_start();
        int lat = 0;
        int cnt0;
        exp_t want;
        cnt0 = done_cnt;
        sb_q.push_back('{16'h6912, 1'b0, 1'b0});
        a = 16'h1234; b = 16'h5678; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 a = 16'h9999; b = 16'h9999; cin = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 3; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (done) begin lat = k; break; end
        end
        want = sb_q.pop_front();
        n_checks++;
        if (lat !== 5 || {sum, cout, err} !== want) begin
            n_fail++;
            $display("FAIL ignore_start: got lat=%0d %h want lat=5 %h", lat, {sum, cout, err}, want);
        end
        repeat (10) @(posedge clk);
        #1;
        n_checks++;
        if (done_cnt - cnt0 !== 1) begin n_fail++; $display("FAIL ignore_start_pulses: got %0d want 1", done_cnt - cnt0); end
    endtask

    task automatic test_reset_mid_run();
        int cnt0;
        a = 16'h1234; b = 16'h5678; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        cnt0 = done_cnt;
        @(posedge clk);
        #1 rst = 1'b0;
        n_checks++;
        if ({busy, done, sum, cout} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_mid_run: got busy=%b done=%b sum=%h cout=%b want all 0", busy, done, sum, cout);
        end
        repeat (10) @(posedge clk);
        #1;
        n_checks++;
        if (done_cnt !== cnt0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_done: got pulses=%0d busy=%b want 0 0", done_cnt - cnt0, busy);
        end
    endtask

    task automatic test_back_to_back();
        int t1 = 0;
        int t2 = 0;
        int cnt0;
        exp_t want;
        cnt0 = done_cnt;
        sb_q.push_back('{16'h0100, 1'b0, 1'b0});
        sb_q.push_back('{16'h0100, 1'b0, 1'b0});
        a = 16'h0042; b = 16'h0058; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                want = sb_q.pop_front();
                n_checks++;
                if ({sum, cout, err} !== want) begin n_fail++; $display("FAIL b2b_result: got %h want %h", {sum, cout, err}, want); end
                if (t1 == 0) t1 = k;
                else begin t2 = k; start = 1'b0; break; end
            end
        end
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        n_checks++;
        if (t1 !== 5 || t2 !== 11 || done_cnt - cnt0 !== 2) begin
            n_fail++;
            $display("FAIL b2b_timing: got t1=%0d t2=%0d pulses=%0d want 5 11 2", t1, t2, done_cnt - cnt0);
        end
        while (sb_q.size() > 0) void'(sb_q.pop_front());
    endtask

    task automatic test_invalid_digit();
        int lat;
        exp_t got, want;
        issue(16'h00A0, 16'h0000, 1'b0, '{16'h0100, 1'b0, 1'b1}, lat, got, want);
        n_checks++;
        if (got !== want) begin n_fail++; $display("FAIL invalid_digit: got %h want %h", got, want); end
        issue(16'h0005, 16'h0005, 1'b0, '{16'h0010, 1'b0, 1'b0}, lat, got, want);
        n_checks++;
        if (got !== want) begin n_fail++; $display("FAIL err_clear: got %h want %h", got, want); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_single_digit();
        test_ignore_start();
        test_reset_mid_run();
        test_back_to_back();
        test_invalid_digit();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
